// File: rtl/sevenseg_scan_decoder.sv
// Monitors a multiplexed active-low seven-segment bus and rebuilds the BCD digit,
// decimal point and legality of every display position; flags frames and bad patterns.
module sevenseg_scan_decoder #(
    parameter int NUM_DIGITS    = 8,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic [NUM_DIGITS-1:0]   an_i,
    input  logic [6:0]              seg_i,
    input  logic                    dp_i,
    output logic [4*NUM_DIGITS-1:0] digit_o,
    output logic [NUM_DIGITS-1:0]   dp_o,
    output logic [NUM_DIGITS-1:0]   digit_valid_o,
    output logic                    frame_valid_o,
    output logic                    err_o
);

    localparam int BUS_W = NUM_DIGITS + 8;
    localparam int CNT_W = 8;
    localparam int POS_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [CNT_W-1:0] STABLE_LIM = CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {BLANK, SETTLE, HOLD} state_t;

    state_t                         state_q, state_d;
    logic [BUS_W-1:0]               smp_q, prev_q;
    logic [CNT_W-1:0]               cnt_q, cnt_d;
    logic [NUM_DIGITS-1:0][3:0]     digit_q, digit_d;
    logic [NUM_DIGITS-1:0]          dp_q, dp_d;
    logic [NUM_DIGITS-1:0]          valid_q, valid_d;
    logic [NUM_DIGITS-1:0]          seen_q, seen_d, seen_set;
    logic                           frame_q, frame_d;
    logic                           err_q, err_d;

    logic [NUM_DIGITS-1:0]          smp_an;
    logic [6:0]                     smp_seg;
    logic                           smp_dp;
    logic                           changed;
    logic [4:0]                     n_low;
    logic [POS_W-1:0]               pos;
    logic                           one_low, multi_low;
    logic [3:0]                     dec_digit;
    logic                           dec_legal;
    logic                           cap, bus_err;

    // Idle bus (everything dark) is the reset value, so a driven digit at release
    // is seen as a change and settles normally.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            smp_q  <= '1;
            prev_q <= '1;
        end else begin
            smp_q  <= {an_i, seg_i, dp_i};
            prev_q <= smp_q;
        end
    end

    assign smp_an  = smp_q[BUS_W-1 -: NUM_DIGITS];
    assign smp_seg = smp_q[7:1];
    assign smp_dp  = smp_q[0];
    assign changed = (smp_q != prev_q);

    always_comb begin
        if (changed)
            cnt_d = CNT_W'(1);
        else if (cnt_q >= STABLE_LIM)
            cnt_d = STABLE_LIM;
        else
            cnt_d = cnt_q + 1'b1;
    end

    always_comb begin
        n_low = '0;
        pos   = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (!smp_an[k]) begin
                n_low = n_low + 5'd1;
                pos   = POS_W'(k);
            end
        end
    end

    assign one_low   = (n_low == 5'd1);
    assign multi_low = (n_low > 5'd1);

    always_comb begin
        dec_legal = 1'b1;
        case (smp_seg)
            7'b1000000: dec_digit = 4'd0;
            7'b1111001: dec_digit = 4'd1;
            7'b0100100: dec_digit = 4'd2;
            7'b0110000: dec_digit = 4'd3;
            7'b0011001: dec_digit = 4'd4;
            7'b0010010: dec_digit = 4'd5;
            7'b0000010: dec_digit = 4'd6;
            7'b1111000: dec_digit = 4'd7;
            7'b0000000: dec_digit = 4'd8;
            7'b0010000: dec_digit = 4'd9;
            7'b1111111: dec_digit = 4'hF;
            default: begin
                dec_digit = 4'hE;
                dec_legal = 1'b0;
            end
        endcase
    end

    // Any bus change re-enters BLANK or SETTLE; the capture test runs on the
    // resolved next state so a one-cycle stability window still works.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        bus_err = 1'b0;
        case (state_q)
            BLANK, SETTLE, HOLD: begin
                if (changed) begin
                    state_d = one_low ? SETTLE : BLANK;
                    bus_err = multi_low;
                end
            end
            default: state_d = BLANK;
        endcase
        if (state_d == SETTLE && cnt_d == STABLE_LIM) begin
            cap     = 1'b1;
            state_d = HOLD;
        end
    end

    always_comb begin
        digit_d  = digit_q;
        dp_d     = dp_q;
        valid_d  = valid_q;
        seen_d   = seen_q;
        seen_set = seen_q;
        frame_d  = 1'b0;
        err_d    = bus_err;
        if (cap) begin
            digit_d[pos]  = dec_digit;
            valid_d[pos]  = dec_legal;
            dp_d[pos]     = ~smp_dp;
            seen_set[pos] = 1'b1;
            if (!dec_legal)
                err_d = 1'b1;
            if (&seen_set) begin
                frame_d = 1'b1;
                seen_d  = '0;
            end else begin
                seen_d  = seen_set;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= BLANK;
            cnt_q   <= '0;
            digit_q <= '1;
            dp_q    <= '0;
            valid_q <= '0;
            seen_q  <= '0;
            frame_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            digit_q <= digit_d;
            dp_q    <= dp_d;
            valid_q <= valid_d;
            seen_q  <= seen_d;
            frame_q <= frame_d;
            err_q   <= err_d;
        end
    end

    assign digit_o       = digit_q;
    assign dp_o          = dp_q;
    assign digit_valid_o = valid_q;
    assign frame_valid_o = frame_q;
    assign err_o         = err_q;

endmodule
